// File: rtl/convergence_monitor.sv
// convergence_monitor: streams old/new weight vectors one element pair per
// beat, accumulates an L1 or max-abs distance (optionally sign-invariant),
// and tracks a pass streak and iteration count to flag convergence or timeout.
module convergence_monitor #(
    parameter int SIZE_N     = 8,
    parameter int DATA_W     = 32,
    parameter int PASS_COUNT = 2,
    parameter int MAX_ITER   = 64,
    parameter int ACC_W      = DATA_W + 1 + $clog2(SIZE_N)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         start,
    input  logic                         mode,
    input  logic                         sign_inv,
    input  logic [ACC_W-1:0]             threshold,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            vec_elem,
    input  logic [DATA_W-1:0]            next_elem,
    output logic                         valid,
    output logic                         converged,
    output logic                         timeout,
    output logic                         busy,
    output logic [ACC_W-1:0]             metric,
    output logic [$clog2(MAX_ITER+1)-1:0] iter_count
);

    localparam int IT_W  = $clog2(MAX_ITER + 1);
    localparam int CNT_W = $clog2(SIZE_N);
    localparam int STK_W = $clog2(PASS_COUNT + 1);

    localparam logic [IT_W-1:0]  ITER_MAX = IT_W'(MAX_ITER);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(PASS_COUNT);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SIZE_N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EVAL  = 2'd2
    } state_t;

    // Magnitude of a DATA_W+1 difference, zero-extended to accumulator width.
    // The most negative input yields 2^DATA_W, which is exact as unsigned.
    function automatic logic [ACC_W-1:0] abs_ext(input logic [DATA_W:0] d);
        logic [DATA_W:0] mag;
        if (d[DATA_W]) begin
            mag = ~d + {{DATA_W{1'b0}}, 1'b1};
        end else begin
            mag = d;
        end
        return {{(ACC_W-DATA_W-1){1'b0}}, mag};
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   accm_q, accm_d, accp_q, accp_d;
    logic [ACC_W-1:0]   thr_q, thr_d, metric_q, metric_d;
    logic               mode_q, mode_d, sinv_q, sinv_d;
    logic [IT_W-1:0]    iter_q, iter_d;
    logic [STK_W-1:0]   streak_q, streak_d;
    logic               conv_q, conv_d, tout_q, tout_d, done_q, done_d;
    logic               valid_q, valid_d, busy_q, busy_d, rdy_q, rdy_d;

    logic [DATA_W:0]    dm_s, dp_s;
    logic [ACC_W-1:0]   abs_m_s, abs_p_s, m_s;
    logic [IT_W-1:0]    iter_nx_s;
    logic [STK_W-1:0]   streak_nx_s;
    logic               conv_nx_s;

    // Per-beat differences and the end-of-iteration evaluation values.
    always_comb begin
        dm_s    = {next_elem[DATA_W-1], next_elem} - {vec_elem[DATA_W-1], vec_elem};
        dp_s    = {next_elem[DATA_W-1], next_elem} + {vec_elem[DATA_W-1], vec_elem};
        abs_m_s = abs_ext(dm_s);
        abs_p_s = abs_ext(dp_s);
        if (sinv_q && (accp_q < accm_q)) begin
            m_s = accp_q;
        end else begin
            m_s = accm_q;
        end
        if (iter_q == ITER_MAX) begin
            iter_nx_s = ITER_MAX;
        end else begin
            iter_nx_s = iter_q + IT_W'(1);
        end
        if (m_s <= thr_q) begin
            if (streak_q == STK_MAX) begin
                streak_nx_s = STK_MAX;
            end else begin
                streak_nx_s = streak_q + STK_W'(1);
            end
        end else begin
            streak_nx_s = {STK_W{1'b0}};
        end
        conv_nx_s = (streak_nx_s == STK_MAX);
    end

    // Next-state logic: FSM, accumulation and result registers; clear overrides all.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accm_d   = accm_q;
        accp_d   = accp_q;
        thr_d    = thr_q;
        mode_d   = mode_q;
        sinv_d   = sinv_q;
        metric_d = metric_q;
        iter_d   = iter_q;
        streak_d = streak_q;
        conv_d   = conv_q;
        tout_d   = tout_q;
        done_d   = done_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    state_d = ACCUM;
                    mode_d  = mode;
                    sinv_d  = sign_inv;
                    thr_d   = threshold;
                    cnt_d   = {CNT_W{1'b0}};
                    accm_d  = {ACC_W{1'b0}};
                    accp_d  = {ACC_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    if (mode_q) begin
                        accm_d = (abs_m_s > accm_q) ? abs_m_s : accm_q;
                        accp_d = (abs_p_s > accp_q) ? abs_p_s : accp_q;
                    end else begin
                        accm_d = accm_q + abs_m_s;
                        accp_d = accp_q + abs_p_s;
                    end
                    if (cnt_q == LAST_IDX) begin
                        state_d = EVAL;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            EVAL: begin
                state_d  = IDLE;
                metric_d = m_s;
                iter_d   = iter_nx_s;
                streak_d = streak_nx_s;
                conv_d   = conv_nx_s;
                tout_d   = !conv_nx_s && (iter_nx_s == ITER_MAX);
                done_d   = conv_nx_s || (iter_nx_s == ITER_MAX);
                valid_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (clear) begin
            state_d  = IDLE;
            cnt_d    = {CNT_W{1'b0}};
            accm_d   = {ACC_W{1'b0}};
            accp_d   = {ACC_W{1'b0}};
            metric_d = {ACC_W{1'b0}};
            iter_d   = {IT_W{1'b0}};
            streak_d = {STK_W{1'b0}};
            conv_d   = 1'b0;
            tout_d   = 1'b0;
            done_d   = 1'b0;
            valid_d  = 1'b0;
        end else begin
            valid_d  = valid_d;
        end
        busy_d = (state_d != IDLE);
        rdy_d  = (state_d == ACCUM);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            accm_q   <= {ACC_W{1'b0}};
            accp_q   <= {ACC_W{1'b0}};
            thr_q    <= {ACC_W{1'b0}};
            mode_q   <= 1'b0;
            sinv_q   <= 1'b0;
            metric_q <= {ACC_W{1'b0}};
            iter_q   <= {IT_W{1'b0}};
            streak_q <= {STK_W{1'b0}};
            conv_q   <= 1'b0;
            tout_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            accm_q   <= accm_d;
            accp_q   <= accp_d;
            thr_q    <= thr_d;
            mode_q   <= mode_d;
            sinv_q   <= sinv_d;
            metric_q <= metric_d;
            iter_q   <= iter_d;
            streak_q <= streak_d;
            conv_q   <= conv_d;
            tout_q   <= tout_d;
            done_q   <= done_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            rdy_q    <= rdy_d;
        end
    end

    assign in_ready   = rdy_q;
    assign valid      = valid_q;
    assign converged  = conv_q;
    assign timeout    = tout_q;
    assign busy       = busy_q;
    assign metric     = metric_q;
    assign iter_count = iter_q;

endmodule

// File: tb/tb_convergence_monitor.sv
// Directed testbench for convergence_monitor (SIZE_N=4, DATA_W=16,
// PASS_COUNT=2, MAX_ITER=5) with hand-computed expected values.
module tb_convergence_monitor;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int PC = 2;
    localparam int MI = 5;
    localparam int AW = 19;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          sign_inv = 1'b0;
    logic          in_valid = 1'b0;
    logic [AW-1:0] threshold = '0;
    logic [DW-1:0] vec_elem = '0;
    logic [DW-1:0] next_elem = '0;
    logic          in_ready, valid, converged, timeout, busy;
    logic [AW-1:0] metric;
    logic [IW-1:0] iter_count;

    int n_checks = 0;
    int n_errors = 0;
    int vec_a[N];
    int nxt_a[N];

    always #5 clk = ~clk;

    convergence_monitor #(
        .SIZE_N(N), .DATA_W(DW), .PASS_COUNT(PC), .MAX_ITER(MI)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear), .start(start), .mode(mode),
        .sign_inv(sign_inv), .threshold(threshold), .in_valid(in_valid),
        .in_ready(in_ready), .vec_elem(vec_elem), .next_elem(next_elem),
        .valid(valid), .converged(converged), .timeout(timeout), .busy(busy),
        .metric(metric), .iter_count(iter_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int v0, v1, v2, v3, input int n0, n1, n2, n3);
        vec_a[0] = v0; vec_a[1] = v1; vec_a[2] = v2; vec_a[3] = v3;
        nxt_a[0] = n0; nxt_a[1] = n1; nxt_a[2] = n2; nxt_a[3] = n3;
    endtask

    task automatic res(input string step, input int m, c, t, it);
        chk({step, "_metric"},    32'(metric),     m);
        chk({step, "_converged"}, 32'(converged),  c);
        chk({step, "_timeout"},   32'(timeout),    t);
        chk({step, "_iter"},      32'(iter_count), it);
    endtask

    // One full iteration; config is scrambled after start to show it is sampled.
    task automatic do_iter(input logic md, input logic si, input int thr, input int bub);
        start = 1'b1; mode = md; sign_inv = si; threshold = AW'(thr);
        tick();
        start = 1'b0; mode = ~md; sign_inv = ~si; threshold = '0;
        chk("busy_on_start", 32'(busy), 1);
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            vec_elem = DW'(vec_a[i]);
            next_elem = DW'(nxt_a[i]);
            tick();
            in_valid = 1'b0;
            vec_elem = 16'h7fff;
            next_elem = 16'h8000;
            if (i < N - 1) begin
                for (int b = 0; b < bub; b++) begin
                    chk("stall_ready", 32'(in_ready), 1);
                    chk("stall_no_valid", 32'(valid), 0);
                    tick();
                end
            end
        end
        chk("valid_low_in_eval", 32'(valid), 0);
        chk("busy_in_eval", 32'(busy), 1);
        tick();
        chk("valid_strobe", 32'(valid), 1);
        chk("idle_after_eval", 32'(busy), 0);
        tick();
        chk("valid_one_cycle", 32'(valid), 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        // reset state
        tick();
        tick();
        res("reset", 0, 0, 0, 0);
        chk("reset_valid", 32'(valid), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ready", 32'(in_ready), 0);
        rst = 1'b0;
        tick();

        // two small-error iterations converge
        load(100, 200, -50, 0, 103, 198, -50, 1);
        do_iter(1'b0, 1'b0, 10, 0);
        res("t1", 6, 0, 0, 1);
        do_iter(1'b0, 1'b0, 10, 0);
        res("t2", 6, 1, 0, 2);

        // start ignored while done
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("done_start_ignored", 32'(busy), 0);
        tick();
        chk("done_no_valid", 32'(valid), 0);
        chk("done_conv_held", 32'(converged), 1);
        do_clear();
        res("clr1", 0, 0, 0, 0);

        // pass / fail / pass / pass : converges only on the 4th
        do_iter(1'b0, 1'b0, 10, 0);
        res("a1", 6, 0, 0, 1);
        load(100, 200, -50, 0, -100, -200, 50, 0);
        do_iter(1'b0, 1'b0, 10, 0);
        res("a2", 700, 0, 0, 2);
        do_iter(1'b0, 1'b1, 10, 0);
        res("a3", 0, 0, 0, 3);
        load(100, 200, -50, 0, 103, 198, -50, 1);
        do_iter(1'b1, 1'b0, 10, 3);
        res("a4", 3, 1, 0, 4);
        do_clear();

        // extreme operands, L1 without wrap
        load(-32768, -32768, -32768, -32768, 32767, 32767, 32767, 32767);
        do_iter(1'b0, 1'b0, 10, 0);
        res("ext", 262140, 0, 0, 1);
        do_clear();

        // five failing iterations reach timeout
        load(100, 200, -50, 0, -100, -200, 50, 0);
        for (int k = 1; k <= MI; k++) begin
            do_iter(1'b0, 1'b0, 10, 0);
            res($sformatf("to%0d", k), 700, 0, (k == MI) ? 1 : 0, k);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("to_start_ignored", 32'(busy), 0);
        tick();
        chk("to_no_valid", 32'(valid), 0);
        chk("to_held", 32'(timeout), 1);
        do_clear();
        res("clr2", 0, 0, 0, 0);
        load(100, 200, -50, 0, 103, 198, -50, 1);
        do_iter(1'b0, 1'b0, 10, 0);
        res("after_clr", 6, 0, 0, 1);

        // async reset in the middle of accumulation
        start = 1'b1; threshold = AW'(10);
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            vec_elem = DW'(vec_a[i]);
            next_elem = DW'(nxt_a[i]);
            tick();
        end
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(in_ready), 0);
        chk("arst_metric", 32'(metric), 0);
        chk("arst_iter", 32'(iter_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        do_iter(1'b0, 1'b0, 10, 0);
        res("post_rst", 6, 0, 0, 1);

        // clear in the middle of accumulation
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            vec_elem = DW'(vec_a[i]);
            next_elem = DW'(nxt_a[i]);
            tick();
        end
        in_valid = 1'b1;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("mclr_busy", 32'(busy), 0);
        chk("mclr_ready", 32'(in_ready), 0);
        chk("mclr_iter", 32'(iter_count), 0);
        for (int c = 0; c < 3; c++) begin
            chk("mclr_no_valid", 32'(valid), 0);
            tick();
        end

        // start and clear together
        start = 1'b1;
        clear = 1'b1;
        tick();
        start = 1'b0;
        clear = 1'b0;
        chk("sc_busy", 32'(busy), 0);
        chk("sc_ready", 32'(in_ready), 0);
        tick();
        chk("sc_no_valid", 32'(valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
